// File: rtl/atmega_dbg_bridge_pkg.sv
// atmega_dbg_bridge_pkg: command bytes and command FSM encoding shared by the debug bridge
package atmega_dbg_bridge_pkg;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_REQ, S_STROBE, S_SEND} state_t;
endpackage

// File: rtl/dbg_uart_phy.sv
// dbg_uart_phy: 8N1 receiver and transmitter with 16x oversampling tick dividers
module dbg_uart_phy #(
  parameter logic [11:0] BAUD_DIV = 12'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx,
  output logic       o_tx_busy,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_ferr
);
  logic [2:0]  r_rx_s;
  logic        r_rx_act, r_rx_valid, r_rx_ferr, r_tx_busy;
  logic [11:0] r_rx_div, r_tx_div;
  logic [3:0]  r_rx_tick, r_rx_bit, r_tx_tick, r_tx_bit;
  logic [7:0]  r_rx_sh;
  logic [9:0]  r_tx_sh;
  logic        w_rx, w_fall;
  assign w_rx       = r_rx_s[1];
  assign w_fall     = r_rx_s[2] & ~r_rx_s[1];
  assign o_tx       = r_tx_sh[0];
  assign o_tx_busy  = r_tx_busy;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_sh;
  assign o_rx_ferr  = r_rx_ferr;
  // two-flop synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rx_s <= 3'b111;
    else     r_rx_s <= {r_rx_s[1:0], i_rx};
  // receiver: divider restarts on the start edge, every bit sampled on its 8th tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_act <= 1'b0; r_rx_div <= '0; r_rx_tick <= '0; r_rx_bit <= '0;
      r_rx_sh <= '0; r_rx_valid <= 1'b0; r_rx_ferr <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_act) begin
        if (w_fall) begin
          r_rx_act <= 1'b1; r_rx_div <= '0; r_rx_tick <= '0; r_rx_bit <= '0;
        end
      end else if (r_rx_div != BAUD_DIV) r_rx_div <= r_rx_div + 12'd1;
      else begin
        r_rx_div  <= '0;
        r_rx_tick <= r_rx_tick + 4'd1;
        if (r_rx_tick == 4'd7) begin
          if (r_rx_bit == 4'd0 && w_rx) r_rx_act <= 1'b0;
          else if (r_rx_bit == 4'd9) begin
            r_rx_act <= 1'b0; r_rx_valid <= w_rx; r_rx_ferr <= ~w_rx;
          end else if (r_rx_bit != 4'd0) r_rx_sh <= {w_rx, r_rx_sh[7:1]};
        end
        if (r_rx_tick == 4'd15) r_rx_bit <= r_rx_bit + 4'd1;
      end
    end
  // transmitter: shift register drives the line directly so reset forces it high at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_busy <= 1'b0; r_tx_sh <= '1; r_tx_div <= '0; r_tx_tick <= '0; r_tx_bit <= '0;
    end else if (!r_tx_busy) begin
      if (i_tx_start) begin
        r_tx_busy <= 1'b1; r_tx_sh <= {1'b1, i_tx_data, 1'b0};
        r_tx_div <= '0; r_tx_tick <= '0; r_tx_bit <= '0;
      end
    end else if (r_tx_div != BAUD_DIV) r_tx_div <= r_tx_div + 12'd1;
    else begin
      r_tx_div  <= '0;
      r_tx_tick <= r_tx_tick + 4'd1;
      if (r_tx_tick == 4'd15) begin
        if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
        else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
        end
      end
    end
endmodule

// File: rtl/atmega_dbg_bridge.sv
// atmega_dbg_bridge: serial debug command decoder acting as IO bus master
module atmega_dbg_bridge import atmega_dbg_bridge_pkg::*; #(
  parameter int          BUS_ADDR_DATA_LEN = 8,
  parameter logic [11:0] BAUD_DIV          = 12'd0,
  parameter logic [23:0] TIMEOUT           = 24'd1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic                         tx,
  output logic                         bus_req,
  input  logic                         bus_gnt,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr,
  output logic                         wr,
  output logic                         rd,
  output logic [7:0]                   bus_out,
  input  logic [7:0]                   bus_in,
  output logic                         busy,
  output logic                         rx_err
);
  state_t                       r_state;
  logic                         r_is_wr, r_bus_req, r_wr, r_rd, r_tx_start, r_rx_err;
  logic [BUS_ADDR_DATA_LEN-1:0] r_addr;
  logic [7:0]                   r_bus_out, r_tx_data;
  logic [23:0]                  r_to;
  logic                         w_rx_valid, w_rx_ferr, w_tx_busy, w_get, w_timeout, w_drop, w_cmd_ok;
  logic [7:0]                   w_rx_data;
  assign w_get     = r_state == S_GET_ADDR || r_state == S_GET_DATA;
  assign w_timeout = w_get && r_to == TIMEOUT;
  assign w_drop    = w_rx_valid && (r_state == S_REQ || r_state == S_STROBE || r_state == S_SEND);
  assign w_cmd_ok  = w_rx_data == CMD_WR || w_rx_data == CMD_RD;
  assign bus_req   = r_bus_req;
  assign addr      = r_addr;
  assign wr        = r_wr;
  assign rd        = r_rd;
  assign bus_out   = r_bus_out;
  assign busy      = r_state != S_IDLE;
  assign rx_err    = r_rx_err;
  dbg_uart_phy #(.BAUD_DIV(BAUD_DIV)) u_phy (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rx),
    .i_tx_start (r_tx_start),
    .i_tx_data  (r_tx_data),
    .o_tx       (tx),
    .o_tx_busy  (w_tx_busy),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .o_rx_ferr  (w_rx_ferr)
  );
  // inter-byte timeout: restarts on every received byte, saturates while collecting a command
  always_ff @(posedge clk or posedge rst)
    if (rst) r_to <= '0;
    else if (w_rx_valid || !w_get) r_to <= '0;
    else if (r_to != TIMEOUT) r_to <= r_to + 24'd1;
  // command FSM: collect bytes, win the bus, strobe once, then send the reply
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE; r_is_wr <= 1'b0; r_bus_req <= 1'b0; r_wr <= 1'b0; r_rd <= 1'b0;
      r_addr <= '0; r_bus_out <= '0; r_tx_data <= '0; r_tx_start <= 1'b0; r_rx_err <= 1'b0;
    end else begin
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_tx_start <= 1'b0;
      r_rx_err   <= w_rx_ferr | w_drop;
      if (w_rx_ferr) begin
        r_state   <= S_IDLE;
        r_bus_req <= 1'b0;
      end else case (r_state)
        S_IDLE: if (w_rx_valid) begin
          r_is_wr    <= w_rx_data == CMD_WR;
          r_tx_data  <= RSP_NAK;
          r_tx_start <= ~w_cmd_ok;
          r_state    <= w_cmd_ok ? S_GET_ADDR : S_SEND;
        end
        S_GET_ADDR:
          if (w_rx_valid) begin
            r_addr    <= BUS_ADDR_DATA_LEN'(w_rx_data);
            r_bus_req <= ~r_is_wr;
            r_state   <= r_is_wr ? S_GET_DATA : S_REQ;
          end else if (w_timeout) r_state <= S_IDLE;
        S_GET_DATA:
          if (w_rx_valid) begin
            r_bus_out <= w_rx_data;
            r_bus_req <= 1'b1;
            r_state   <= S_REQ;
          end else if (w_timeout) r_state <= S_IDLE;
        S_REQ: if (bus_gnt) begin
          r_wr    <= r_is_wr;
          r_rd    <= ~r_is_wr;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_bus_req  <= 1'b0;
          r_tx_data  <= r_rd ? bus_in : RSP_ACK;
          r_tx_start <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: if (!r_tx_start && !w_tx_busy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/atmega_dbg_bridge.md
Name: atmega_dbg_bridge

Overview:
- Serial debug initiator for the ATmega IO bus: the bus-master end of the register interface that our UART and other peripherals respond on.
- Receives 8N1 command frames on a dedicated debug pin, arbitrates for the IO bus, issues one-cycle wr/rd strobes, and returns an ACK, NAK or read data over its own serial TX.
- Sits beside the CPU core. The core must release the bus when bus_gnt is asserted.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of addr.
- BAUD_DIV, 12'd0, oversample divisor in UBRR semantics. Tick every BAUD_DIV+1 clocks; 16 ticks per bit.
- TIMEOUT, 24'd1000000, clocks allowed between bytes of one command before the command is silently abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx  in  1  debug serial input, asynchronous to clk.
- tx  out  1  debug serial output, idle high.
- bus_req  out  1  bus request to the core/arbiter.
- bus_gnt  in  1  bus grant; bridge owns addr/wr/rd/bus_out only while it is high.
- addr  out  BUS_ADDR_DATA_LEN  IO address.
- wr  out  1  write strobe, one cycle.
- rd  out  1  read strobe, one cycle.
- bus_out  out  8  write data to peripherals.
- bus_in  in  8  read data from peripherals, combinational during rd.
- busy  out  1  high whenever the FSM is not in IDLE.
- rx_err  out  1  one-cycle pulse on framing error or dropped byte.

Behaviour:
- Reset values: tx=1, bus_req=0, wr=0, rd=0, addr=0, bus_out=0, busy=0, rx_err=0. PHY and FSM return to idle.
- Reset mid-frame: abort immediately and asynchronously. tx goes high with no partial byte completed.
- RX PHY:
  - rx is synchronised through 2 flops.
  - A falling edge in RX idle starts tick counting. At tick 8 the start bit is re-checked; if high, it is a false start and the PHY returns to idle.
  - Data bits are sampled LSB-first at tick 8 of each bit. The stop bit is sampled at tick 8.
  - Stop=1: rx_valid pulses one cycle with the byte.
  - Stop=0: rx_err pulses, the byte is discarded, and the FSM is forced to IDLE.
- TX PHY:
  - tx_start with tx_data accepted only when not tx_busy.
  - Frame is start(0), 8 data bits LSB-first, stop(1), each bit 16*(BAUD_DIV+1) clocks.
  - tx_busy drops at the end of the stop bit.
- Command set:
  - 0x57 'W', addr, data → bus write, reply 0x06.
  - 0x52 'R', addr → bus read, reply the read byte.
  - Any other first byte → reply 0x15, return to IDLE.
- FSM: IDLE → GET_ADDR → (GET_DATA for W) → REQ → STROBE → SEND → IDLE. NAK path is IDLE → SEND.
- REQ:
  - bus_req=1.
  - On the first edge where bus_gnt=1, go to STROBE.
  - wr or rd is high for exactly the STROBE cycle, with addr/bus_out valid.
  - rd cycle latches bus_in at the closing edge.
  - bus_req stays high through STROBE and drops the cycle after.
- Grant loss: if bus_gnt falls during REQ before the strobe, keep waiting. The strobe is never issued without grant.
- SEND: pulse tx_start once, wait for tx_busy low, then IDLE.
- Timeout:
  - Counter clears on each rx_valid.
  - In GET_ADDR or GET_DATA, reaching TIMEOUT returns to IDLE with no reply.
- Bytes received while in REQ, STROBE or SEND are dropped with an rx_err pulse; no queueing.
- Simultaneous rx_err and a timeout expiry: one return to IDLE, one rx_err pulse.
- Counter widths: tick counter 12 bits, bit counter 4 bits, timeout counter 24 bits. No wrap-around: counters saturate or reload.

Decomposition:
- Shared package holds:
  - command constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15;
  - FSM state encoding.
- One sub-module, dbg_uart_phy: the 8N1 RX and TX with the tick generator. The top holds the command FSM, timeout and bus interface.

Test Plan:
All scenarios use BAUD_DIV=0 (16 clocks/bit) and TIMEOUT=2000.
1. Write: send 0x57,0xC1,0xA5 with bus_gnt=1 → exactly one wr cycle with addr=0xC1, bus_out=0xA5; tx emits 0x06; busy returns low.
2. Read: send 0x52,0xC8 with bus_in=0x20 while rd → one rd cycle at addr=0xC8; tx emits 0x20.
3. Bad command: send 0x41 → tx emits 0x15; wr and rd never assert; bus_req stays 0.
4. Delayed grant: bus_gnt=0 for 100 cycles after a write command → bus_req held high, no wr; wr asserts the cycle after bus_gnt rises; bus_req drops one cycle after wr.
5. Timeout: send 0x57 then idle for 2500 cycles → no strobe, no reply; a following 0x52,0xC8 completes normally.
6. Errors: a frame with stop=0 → rx_err pulse, no reply; asserting rst mid-reply → tx=1 in the same cycle and all outputs at reset values.
